// File: rtl/rr_output_arbiter.sv
// Round-robin wormhole arbiter for one router output port: picks one of N inputs,
// holds the one-hot crossbar select for the whole packet, then rotates priority.
module rr_output_arbiter #(
  parameter int N    = 5,
  parameter int IDXW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    tail,
  input  logic            out_ready,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            busy,
  output logic            xfer
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    grant_nxt;
  logic [IDXW-1:0] idx_nxt, ptr, ptr_nxt, pick;
  logic            found;

  assign busy = (state == BUSY);
  assign xfer = busy & req[grant_idx] & out_ready;

  // Rotating search: first requester at or after ptr, wrapping modulo N.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IDXW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    idx_nxt   = grant_idx;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = BUSY;
          grant_nxt = N'(1) << pick;
          idx_nxt   = pick;
        end
      end
      BUSY: begin
        // Release only on an accepted tail flit from the owning input.
        if (xfer && tail[grant_idx]) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          idx_nxt   = '0;
          ptr_nxt   = (grant_idx == IDXW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      ptr       <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      grant_idx <= idx_nxt;
      ptr       <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_rr_output_arbiter.sv
// Self-checking bench for rr_output_arbiter: directed scenarios plus random
// traffic compared against an owner/pointer reference model.
module tb_rr_output_arbiter;

  localparam int N    = 5;
  localparam int IDXW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    tail;
  logic            out_ready;
  logic [N-1:0]    grant;
  logic [IDXW-1:0] grant_idx;
  logic            busy;
  logic            xfer;

  int checks   = 0;
  int failures = 0;

  // Reference model: owning input (-1 when idle) and round-robin start point.
  int m_owner = -1;
  int m_ptr   = 0;

  rr_output_arbiter #(.N(N), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .req(req), .tail(tail), .out_ready(out_ready),
    .grant(grant), .grant_idx(grant_idx), .busy(busy), .xfer(xfer)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_grant"}, 32'(grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check({tag, "_idx"},   32'(grant_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check({tag, "_busy"},  32'(busy), (m_owner < 0) ? 32'd0 : 32'd1);
  endtask

  // Apply inputs for one cycle, check xfer, advance model and DUT one edge, check state.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] t, input logic o);
    logic exp_xfer;
    req = r; tail = t; out_ready = o;
    #1;
    exp_xfer = (m_owner >= 0) && r[m_owner] && o;
    check("xfer", 32'(xfer), 32'(exp_xfer));
    if (m_owner < 0) begin
      m_owner = rr_pick(r, m_ptr);
    end else if (exp_xfer && t[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end
    @(posedge clk);
    #1;
    check_outputs("state");
  endtask

  // Asynchronous reset pulse placed away from any clock edge.
  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    m_owner = -1;
    m_ptr   = 0;
    check_outputs("async_rst");
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [N-1:0] fair_exp [11];
    int n;
    fair_exp = '{5'b00001, 5'b0, 5'b00010, 5'b0, 5'b00100, 5'b0,
                 5'b01000, 5'b0, 5'b10000, 5'b0, 5'b00001};

    rst = 1'b0; req = '0; tail = '0; out_ready = 1'b0;
    #1;
    check_outputs("reset");
    #2 rst = 1'b1;

    // Idle with no requests stays idle.
    step('0, '0, 1'b1);

    // Reset mid-packet on input 2, then re-arbitrate from ptr=0.
    step(5'b00100, '0, 1'b1);
    step(5'b00100, '0, 1'b1);
    pulse_reset();
    step(5'b00110, '0, 1'b0);
    check("rst_rearb", 32'(grant), 32'b00010);
    step(5'b00010, 5'b00010, 1'b1);

    // Three-flit packet from input 2.
    step(5'b00100, '0, 1'b1);
    step(5'b00100, '0, 1'b1);
    step(5'b00100, '0, 1'b1);
    step(5'b00100, 5'b00100, 1'b1);
    check("pkt3_release", 32'(grant), 32'd0);

    // Fairness with all inputs requesting single-flit packets.
    pulse_reset();
    for (int k = 0; k < 11; k++) begin
      step(5'b11111, 5'b11111, 1'b1);
      check("fair_seq", 32'(grant), 32'(fair_exp[k]));
    end

    // Backpressure: 4-flit packet from input 0 with out_ready toggling.
    pulse_reset();
    step(5'b01001, '0, 1'b1);
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      logic o;
      o = (c % 2) == 0;
      step(5'b01001, (n == 3) ? 5'b00001 : 5'b00000, o);
      if (o) n++;
      if (n < 4) check("bp_hold", 32'(grant), 32'b00001);
    end
    check("bp_flits", 32'(n), 32'd4);
    step(5'b01001, '0, 1'b1);
    check("bp_next", 32'(grant), 32'b01000);
    step(5'b01000, 5'b01000, 1'b1);

    // Granted input stalls without a tail; other requester must wait.
    pulse_reset();
    step(5'b00010, '0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(5'b01000, 5'b01000, 1'b1);
      check("stall_hold", 32'(grant), 32'b00010);
    end
    step(5'b00010, 5'b00010, 1'b1);

    // Wrap-around after input 4 releases.
    pulse_reset();
    step(5'b10000, '0, 1'b1);
    step(5'b10000, 5'b10000, 1'b1);
    step(5'b10001, 5'b10001, 1'b1);
    check("wrap_first", 32'(grant), 32'b00001);
    step(5'b10001, 5'b10001, 1'b1);
    step(5'b10001, 5'b10001, 1'b1);
    check("wrap_second", 32'(grant), 32'b10000);
    step(5'b10000, 5'b10000, 1'b1);

    // Random traffic with occasional asynchronous resets.
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 99) == 0) pulse_reset();
      step(N'($urandom_range(0, 31)), N'($urandom_range(0, 31)),
           $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
